// File: rtl/rv32i_rf_wr_arbiter.sv
// rv32i_rf_wr_arbiter: shares the RF write port between writeback and a queued secondary stream (optional direct path: RF_WR_ARB_BYPASS_EN)
module rv32i_rf_wr_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_wr,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  input  logic        i_sec_valid,
  input  logic [4:0]  i_sec_addr,
  input  logic [31:0] i_sec_data,
  output logic        o_sec_ready,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_addr,
  output logic [31:0] o_rf_data,
  output logic        o_sec_pending
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {NORMAL, FORCE} state_t;
  state_t state;
  logic [4:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld, q_kill;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0] starve;
  logic wb_acc, wb_we, head_vld, head_live, head_grant, pop, push, push_kill, byp;
  // Arbitration: x0 pushes enter already killed so they drain silently and never count as pending
  always_comb begin
    o_wb_stall = state == FORCE;
    o_sec_ready = !q_vld[wr_ptr];
    o_sec_pending = |(q_vld & ~q_kill);
    wb_acc = i_wb_wr & !o_wb_stall;
    wb_we = wb_acc & (i_wb_addr != 5'd0);
    head_vld = q_vld[rd_ptr];
    head_live = head_vld & !q_kill[rd_ptr];
    head_grant = head_live & (o_wb_stall | !i_wb_wr);
    pop = head_vld & (q_kill[rd_ptr] | head_grant);
`ifdef RF_WR_ARB_BYPASS_EN
    byp = !o_sec_pending & !o_wb_stall & !i_wb_wr & i_sec_valid & o_sec_ready;
`else
    byp = 1'b0;
`endif
    push = i_sec_valid & o_sec_ready & !byp;
    push_kill = (i_sec_addr == 5'd0) | (wb_we & (i_sec_addr == i_wb_addr));
  end
  // FIFO occupancy and kill bits; a writeback kills every queued entry to the same register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_vld <= '0;
      q_kill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (q_vld[i] && wb_we && q_addr[i] == i_wb_addr) q_kill[i] <= 1'b1;
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        q_kill[wr_ptr] <= push_kill;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end
  // FIFO payload storage, qualified by q_vld so it needs no reset
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= i_sec_addr;
      q_data[wr_ptr] <= i_sec_data;
    end
  end
  // Starvation guard: count denied cycles of a live head, force one stalled writeback cycle at the limit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= NORMAL;
      starve <= '0;
    end else if (state == FORCE) begin
      state <= NORMAL;
      starve <= '0;
    end else if (pop) begin
      starve <= '0;
    end else if (head_live && i_wb_wr) begin
      starve <= starve + 8'd1;
      if (starve + 8'd1 == 8'(STARVE_LIMIT)) state <= FORCE;
    end
  end
  // Registered write port: writeback first, then the FIFO head, then the direct secondary path
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rf_we <= 1'b0;
      o_rf_addr <= '0;
      o_rf_data <= '0;
    end else begin
      o_rf_we <= wb_we | head_grant | (byp & (i_sec_addr != 5'd0));
      if (wb_acc) begin
        o_rf_addr <= i_wb_addr;
        o_rf_data <= i_wb_data;
      end else if (head_grant) begin
        o_rf_addr <= q_addr[rd_ptr];
        o_rf_data <= q_data[rd_ptr];
      end else if (byp) begin
        o_rf_addr <= i_sec_addr;
        o_rf_data <= i_sec_data;
      end
    end
  end
endmodule
